// File: rtl/_piso_shifter8.sv
// ---------------------------------------------------------------------------
// _piso_shifter8
// Parallel-in serial-out shifter at the unload end of the register path.
// A word is taken in through a valid/ready handshake. Its bits are then
// presented one at a time, and a bit advances only when the consumer strobes
// shift_en. After the last bit is consumed, done pulses for one cycle.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   load_valid  a parallel word on d is offered
//   d           parallel data word
//   load_ready  the shifter can accept a word (IDLE)
//   shift_en    the consumer takes the current serial bit this cycle
//   s_out       current serial bit (0 when idle)
//   s_valid     s_out holds a valid bit
//   done        one-cycle pulse in the first IDLE cycle after the last bit
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no word held; load_ready=1, waiting for load_valid
// ST_SHIFT | word held; s_out valid, advancing on each shift_en
// ---------------------------------------------------------------------------
module _piso_shifter8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] d,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] sreg_shifted;

  // The register always moves toward the output end, and a zero fills the
  // vacated bit. A drained register therefore reads back as all zeros.
  always_comb begin
    sreg_shifted = '0;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          sreg_d  = d;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          sreg_d = sreg_shifted;
          // Leave before the counter can wrap.
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded from registered state, so the first bit appears in
  // the cycle right after the load edge and holds steady through stalls.
  always_comb begin
    load_ready = (state_q == ST_IDLE);
    s_valid    = (state_q == ST_SHIFT);
    s_out      = 1'b0;
    if (state_q == ST_SHIFT) begin
      s_out = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    end
    done = done_q;
  end

endmodule

// File: tb/tb__piso_shifter8.sv
module tb__piso_shifter8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_valid;
  logic [7:0] d;
  logic       shift_en;

  logic lr0, so0, sv0, dn0;
  logic lr1, so1, sv1, dn1;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue holds the bits that have not been consumed yet.
  // An empty queue means idle.
  bit q0[$];
  bit q1[$];
  bit done_m;

  always #5 clk = ~clk;

  _piso_shifter8 #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .d(d),
    .load_ready(lr0), .shift_en(shift_en), .s_out(so0), .s_valid(sv0), .done(dn0)
  );

  _piso_shifter8 #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .d(d),
    .load_ready(lr1), .shift_en(shift_en), .s_out(so1), .s_valid(sv1), .done(dn1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit b0, b1;
    b0 = (q0.size() != 0) ? q0[0] : 1'b0;
    b1 = (q1.size() != 0) ? q1[0] : 1'b0;
    chk({tag, " lsb.load_ready"}, {7'd0, lr0}, {7'd0, q0.size() == 0});
    chk({tag, " lsb.s_valid"},    {7'd0, sv0}, {7'd0, q0.size() != 0});
    chk({tag, " lsb.s_out"},      {7'd0, so0}, {7'd0, b0});
    chk({tag, " lsb.done"},       {7'd0, dn0}, {7'd0, done_m});
    chk({tag, " msb.load_ready"}, {7'd0, lr1}, {7'd0, q1.size() == 0});
    chk({tag, " msb.s_valid"},    {7'd0, sv1}, {7'd0, q1.size() != 0});
    chk({tag, " msb.s_out"},      {7'd0, so1}, {7'd0, b1});
    chk({tag, " msb.done"},       {7'd0, dn1}, {7'd0, done_m});
  endtask

  // Drive the inputs for one cycle, advance the model at the edge, and
  // compare on the falling edge.
  task automatic cycle(input string tag, input logic lv, input logic [7:0] dv, input logic se);
    bit nd;
    load_valid = lv;
    d          = dv;
    shift_en   = se;
    @(posedge clk);
    nd = 1'b0;
    if (q0.size() == 0) begin
      if (lv) begin
        for (int i = 0; i < 8; i++) begin
          q0.push_back(dv[i]);
          q1.push_back(dv[7-i]);
        end
      end
    end else if (se) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      if (q0.size() == 0) nd = 1'b1;
    end
    done_m = nd;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    done_m = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] rd;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    d          = 8'h00;
    shift_en   = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // LSB-first 8'hA5 with shift_en held high; the LSB stream is rebuilt
    // into a byte and compared as well.
    cycle("a5_load", 1'b1, 8'hA5, 1'b0);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      got[i] = so0;
      cycle("a5_shift", 1'b0, 8'h00, 1'b1);
    end
    chk("a5_lsb_stream", got, 8'hA5);
    cycle("a5_idle", 1'b0, 8'h00, 1'b0);

    // 8'h3C. The MSB-first stream is rebuilt MSB-first.
    cycle("3c_load", 1'b1, 8'h3C, 1'b1);
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      got[7-i] = so1;
      cycle("3c_shift", 1'b0, 8'h00, 1'b1);
    end
    chk("3c_msb_stream", got, 8'h3C);
    cycle("3c_idle", 1'b0, 8'h00, 1'b1);

    // Stall pattern 1,0,0,1,... with 8'hFF offered during SHIFT.
    cycle("f0_load", 1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 24 && q0.size() != 0; i++) begin
      cycle("f0_stall", 1'b1, 8'hFF, (i % 3) == 0);
    end
    cycle("f0_after", 1'b0, 8'h00, 1'b0);

    // Back-to-back: the second load is accepted in the done cycle.
    cycle("81_load", 1'b1, 8'h81, 1'b0);
    for (int i = 0; i < 8; i++) cycle("81_shift", 1'b0, 8'h00, 1'b1);
    chk("81_done_ready", {6'd0, dn0, lr0}, 8'h03);
    cycle("7e_load", 1'b1, 8'h7E, 1'b1);
    for (int i = 0; i < 8; i++) cycle("7e_shift", 1'b0, 8'h00, 1'b1);
    cycle("7e_idle", 1'b0, 8'h00, 1'b0);

    // Reset mid-word, asserted between clock edges.
    cycle("ff_load", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ff_shift", 1'b0, 8'h00, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    cycle("rst_nodone", 1'b0, 8'h00, 1'b1);
    cycle("01_load", 1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) cycle("01_shift", 1'b0, 8'h00, 1'b1);
    cycle("01_idle", 1'b0, 8'h00, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rd = 8'($urandom);
      cycle("rand", ($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/_piso_shifter8.md
Name: _piso_shifter8

Overview:
- Parallel-in serial-out shifter. It is the unload end of the 8-bit register path.
- Accepts a parallel word through a valid/ready load handshake, then emits it one bit per accepted shift strobe.
- Pulses done after the last bit.
- Sits between a parallel register stage and a bit-serial consumer, such as a serial link transmitter or a downstream SIPO register.

Parameters:
- WIDTH, 8, word width in bits; legal values ≥ 2.
- MSB_FIRST, 0, serial bit order; 0 = bit 0 first, 1 = bit WIDTH-1 first.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- load_valid  input  1  parallel word on d is offered.
- d  input  WIDTH  parallel data word.
- load_ready  output  1  shifter can accept a word.
- shift_en  input  1  consumer accepts the current serial bit this cycle.
- s_out  output  1  current serial bit.
- s_valid  output  1  s_out holds a valid bit.
- done  output  1  one-cycle pulse: the last bit was consumed on the previous edge.

Behaviour:
- Clocking and reset:
  - Single clock domain. All state updates on the rising edge of clk.
  - reset_n low clears state asynchronously, independent of clk.
  - Reset values: state=IDLE, shift register=0, bit counter=0, s_out=0, s_valid=0, done=0, load_ready=1.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1, s_valid=0, s_out=0.
  - shift_en is ignored.
  - Load accepted on an edge where load_valid=1: d is captured into the shift register, counter=0, next state=SHIFT.
- SHIFT:
  - load_ready=0, s_valid=1.
  - s_out = sreg[0] when MSB_FIRST=0, sreg[WIDTH-1] when MSB_FIRST=1.
  - Output is driven combinationally from registered state, with no extra latency.
  - On an edge with shift_en=1:
    - Register shifts toward the output end; vacated bit is filled with 0.
    - Counter increments.
    - If counter was WIDTH-1, next state=IDLE and done=1 for the following cycle.
  - shift_en=0 holds all state, so s_out is stable across stalls of any length.
  - load_valid is ignored while in SHIFT; load_ready=0 blocks it.
- done:
  - Registered; high exactly one cycle, coinciding with the first IDLE cycle.
  - Never high otherwise.
- Latency:
  - First bit is valid one cycle after the load edge.
  - A word with shift_en held high occupies exactly WIDTH cycles in SHIFT.
- Back-to-back words: load_ready is high in the done cycle, so a load there is accepted. The next word's first bit appears the following cycle, giving one idle-bubble cycle between words.
- Counter width: clog2(WIDTH). No wrap-around past WIDTH-1; state exits to IDLE first.
- Reset mid-operation: aborts the word immediately. Outputs return to reset values with no done pulse, and the partial word is discarded.
- Data on d is sampled only on the load edge; later changes to d have no effect.

Test Plan:
- Reset: assert reset_n=0 asynchronously mid-cycle with no clk edge -> s_out=0, s_valid=0, done=0, load_ready=1 immediately.
- LSB-first word: MSB_FIRST=0, load d=8'hA5, shift_en held 1 -> s_out sequence 1,0,1,0,0,1,0,1 over 8 cycles with s_valid=1; done high on cycle 9 with load_ready=1.
- MSB-first word: MSB_FIRST=1, load d=8'h3C, shift_en held 1 -> s_out sequence 0,0,1,1,1,1,0,0; done pulses once.
- Stall: load 8'hF0, toggle shift_en 1,0,0,1,... -> s_out holds during shift_en=0; all 8 bits are delivered in order; load_valid=1 with d=8'hFF during SHIFT is not captured.
- Back-to-back: load 8'h81, then load 8'h7E in the done cycle -> stream 1,0,0,0,0,0,0,1, one gap cycle, then 0,1,1,1,1,1,1,0; two done pulses.
- Reset mid-word: load 8'hFF, shift 3 bits, pulse reset_n low -> s_valid=0 and no done pulse; next load 8'h01 shifts out cleanly as 1,0,0,0,0,0,0,0.
